rice_encoder: RTL and testbench

// Golomb-Rice bit-stream encoder, the transmit-side counterpart of the unary-prefix decoder in decode/.

---
 rtl/rice_encoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rice_encoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_encoder.sv
// rice_encoder: Golomb-Rice bit-stream encoder.
// Each accepted symbol is turned into a unary quotient (ones), a terminating
// zero and k remainder bits, or an escape code (Q_ESC ones followed by the raw
// symbol) for large quotients. Codes are packed MSB-first into W_OUT-bit words
// through a 2*W_OUT-bit accumulator. A flush request drains any partial word.

// Simulation-only guard on the Rice parameter of accepted symbols.
module rice_encoder_chk #(
  parameter int W_SYM = 16,
  parameter int KW    = $clog2(W_SYM)
) (
  input logic          clk,
  input logic          rst_n,
  input logic          sym_fire,
  input logic [KW-1:0] s_k
);

  // Report any accepted symbol whose k lies outside 0..W_SYM-1.
  always @(posedge clk) begin
    if (rst_n && sym_fire) begin
      assert (32'(s_k) < W_SYM)
      else $error("rice_encoder: s_k=%0d out of range, using k mod W_SYM", s_k);
    end
  end

endmodule

module rice_encoder #(
  parameter int W_SYM = 16,
  parameter int W_OUT = 32,
  parameter int Q_ESC = 16,
  parameter int KW    = $clog2(W_SYM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [W_SYM-1:0]           s_data,
  input  logic [KW-1:0]              s_k,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [W_OUT-1:0]           m_data,
  output logic [$clog2(W_OUT+1)-1:0] m_bits
);

  localparam int ACC_W = 2 * W_OUT;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int BW    = $clog2(W_OUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_TAIL   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // Registered state and its next-state values.
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [FW-1:0]    rem_q, rem_d;
  logic             esc_q, esc_d;
  logic [W_SYM-1:0] sym_q, sym_d;
  logic [W_SYM-1:0] r_q, r_d;
  logic [KW-1:0]    k_q, k_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [W_OUT-1:0] m_data_q, m_data_d;
  logic [BW-1:0]    m_bits_q, m_bits_d;
  logic             flush_done_q, flush_done_d;

  // Combinational helpers.
  logic [KW-1:0]    k_eff_s;
  logic [W_SYM-1:0] quo_s;
  logic [W_SYM-1:0] rmask_s;
  logic             esc_s;
  logic [FW-1:0]    unary_s;
  logic [FW-1:0]    free_s;
  logic [FW-1:0]    tlen_s;
  logic [W_SYM-1:0] tval_s;
  logic             pop_s;
  logic [FW-1:0]    n_s;
  logic [FW-1:0]    add_s;
  logic [ACC_W-1:0] ins_s;
  logic [ACC_W-1:0] acc_app_s;
  logic [FW-1:0]    fill_app_s;

  function automatic logic [FW-1:0] min3(input logic [FW-1:0] a,
                                         input logic [FW-1:0] b,
                                         input logic [FW-1:0] c);
    logic [FW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Split the offered symbol into quotient, remainder and escape decision.
  always_comb begin
    k_eff_s = KW'(32'(s_k) % W_SYM);
    quo_s   = s_data >> k_eff_s;
    rmask_s = (W_SYM'(1'b1) << k_eff_s) - W_SYM'(1'b1);
    esc_s   = (32'(quo_s) >= Q_ESC);
    if (esc_s) begin
      unary_s = FW'(Q_ESC);
    end else begin
      unary_s = FW'(quo_s);
    end
  end

  // Tail contents, free accumulator space and output pop for this cycle.
  always_comb begin
    free_s = FW'(ACC_W) - fill_q;
    if (esc_q) begin
      // Escape tail: the raw symbol, no terminating zero.
      tlen_s = FW'(W_SYM);
      tval_s = sym_q;
    end else begin
      // Normal tail: '0' then k remainder bits; r < 2^k keeps the top bit 0.
      tlen_s = FW'(k_q) + FW'(1'b1);
      tval_s = r_q;
    end
    pop_s = m_valid_q & m_ready;
  end

  // Next state, accumulator append/pop and next registered output values.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    esc_d        = esc_q;
    sym_d        = sym_q;
    r_d          = r_q;
    k_d          = k_q;
    n_s          = '0;
    add_s        = '0;
    ins_s        = '0;
    flush_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          esc_d = esc_s;
          sym_d = s_data;
          r_d   = s_data & rmask_s;
          k_d   = k_eff_s;
          rem_d = unary_s;
          if (quo_s != '0) begin
            state_d = ST_PREFIX;
          end else begin
            state_d = ST_TAIL;
          end
        end else if (flush && !flush_done_q) begin
          // A level held through the done pulse must not start a second flush.
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREFIX: begin
        n_s   = min3(rem_q, FW'(W_OUT), free_s);
        ins_s = ((ACC_W'(1'b1) << n_s) - ACC_W'(1'b1)) << (free_s - n_s);
        add_s = n_s;
        rem_d = rem_q - n_s;
        if (rem_d == '0) begin
          state_d = ST_TAIL;
        end else begin
          state_d = ST_PREFIX;
        end
      end
      ST_TAIL: begin
        if (free_s >= tlen_s) begin
          ins_s   = ACC_W'(tval_s) << (free_s - tlen_s);
          add_s   = tlen_s;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TAIL;
        end
      end
      ST_FLUSH: begin
        state_d = ST_FLUSH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New bits land below the current fill; a pop removes the presented word.
    acc_app_s  = acc_q | ins_s;
    fill_app_s = fill_q + add_s;
    if (pop_s) begin
      acc_d  = acc_app_s << W_OUT;
      fill_d = fill_app_s - FW'(m_bits_q);
    end else begin
      acc_d  = acc_app_s;
      fill_d = fill_app_s;
    end

    // A flush completes as soon as the accumulator is empty.
    if ((state_d == ST_FLUSH) && (fill_d == '0)) begin
      state_d      = ST_IDLE;
      flush_done_d = 1'b1;
    end else begin
      flush_done_d = 1'b0;
    end

    // Full words are always presented; a partial word only while flushing.
    m_valid_d = (fill_d >= FW'(W_OUT)) || (state_d == ST_FLUSH);
    if (!m_valid_d) begin
      m_bits_d = '0;
      m_data_d = '0;
    end else if (fill_d >= FW'(W_OUT)) begin
      m_bits_d = BW'(W_OUT);
      m_data_d = acc_d[ACC_W-1 -: W_OUT];
    end else begin
      m_bits_d = BW'(fill_d);
      m_data_d = acc_d[ACC_W-1 -: W_OUT];
    end

    s_ready_d = (state_d == ST_IDLE) && (fill_d < FW'(W_OUT));
  end

  // State, accumulator and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      fill_q       <= '0;
      rem_q        <= '0;
      esc_q        <= 1'b0;
      sym_q        <= '0;
      r_q          <= '0;
      k_q          <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_bits_q     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      rem_q        <= rem_d;
      esc_q        <= esc_d;
      sym_q        <= sym_d;
      r_q          <= r_d;
      k_q          <= k_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_bits_q     <= m_bits_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_bits     = m_bits_q;
  assign flush_done = flush_done_q;

  rice_encoder_chk #(
    .W_SYM (W_SYM),
    .KW    (KW)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_fire (s_valid & s_ready_q),
    .s_k      (s_k)
  );

endmodule

// File: tb/tb_rice_encoder.sv
// tb_rice_encoder: random and directed stimulus for rice_encoder, checked
// against a bit-queue model of the Golomb-Rice code stream.
module tb_rice_encoder;

  localparam int W_SYM = 16;
  localparam int W_OUT = 32;
  localparam int Q_ESC = 16;
  localparam int KW    = 4;
  localparam int BW    = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [W_SYM-1:0] s_data = '0;
  logic [KW-1:0]    s_k = '0;
  logic             flush = 1'b0;
  logic             flush_done;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [W_OUT-1:0] m_data;
  logic [BW-1:0]    m_bits;

  rice_encoder #(.W_SYM(W_SYM), .W_OUT(W_OUT), .Q_ESC(Q_ESC), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_k(s_k), .flush(flush), .flush_done(flush_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bits(m_bits)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          bq[$];
  logic [31:0] exp_data[$];
  int          exp_bits[$];
  int          mode = 0;          // 0: always ready, 1: random ready
  bit          force_stall = 1'b0;
  bit          stall_seen_low = 1'b0;
  logic [31:0] last_data = '0;
  int          last_bits = 0;
  int          words_rx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference code for one symbol, straight from the Golomb-Rice definition.
  function automatic void code_of(input logic [15:0] d, input int k,
                                  output int len, output logic [63:0] val);
    int q;
    q = int'(d) >> k;
    if (q >= Q_ESC) begin
      len = Q_ESC + W_SYM;
      val = (((64'd1 << Q_ESC) - 64'd1) << W_SYM) | 64'(d);
    end else begin
      len = q + 1 + k;
      val = (((64'd1 << q) - 64'd1) << (k + 1)) | (64'(d) & ((64'd1 << k) - 64'd1));
    end
  endfunction

  task automatic model_push(input logic [15:0] d, input int k);
    int          len;
    logic [63:0] val;
    logic [31:0] w;
    code_of(d, k, len, val);
    for (int i = len - 1; i >= 0; i--) bq.push_back(val[i]);
    while (bq.size() >= W_OUT) begin
      w = '0;
      for (int i = 0; i < W_OUT; i++) w = {w[30:0], bq.pop_front()};
      exp_data.push_back(w);
      exp_bits.push_back(W_OUT);
    end
  endtask

  task automatic model_flush();
    int          n;
    logic [31:0] w;
    n = bq.size();
    if (n > 0) begin
      w = '0;
      for (int i = 0; i < n; i++) w[31-i] = bq.pop_front();
      exp_data.push_back(w);
      exp_bits.push_back(n);
    end
  endtask

  task automatic model_clear();
    bq.delete();
    exp_data.delete();
    exp_bits.delete();
  endtask

  task automatic send(input logic [15:0] d, input int k);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_k     = 4'(k);
    while (!ok && t < 1000) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        ok = 1'b1;
        model_push(d, k);
      end
      t++;
    end
    #1;
    s_valid = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic send_rand();
    logic [15:0] d;
    int          k;
    d = 16'($urandom);
    k = int'($urandom_range(0, 15));
    if ($urandom_range(0, 2) != 0) d = d >> $urandom_range(6, 15);
    send(d, k);
  endtask

  task automatic do_flush();
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    model_flush();
    flush = 1'b1;
    while (!ok && t < 3000) begin
      @(negedge clk);
      if (flush_done) ok = 1'b1;
      t++;
    end
    flush = 1'b0;
    chk("flush_done_seen", 64'(ok), 64'd1);
    chk("flush_drained", 64'(exp_data.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (force_stall) m_ready = 1'b0;
      else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
    end
  end

  // Output compare: every accepted word against the model, and hold while stalled.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [BW-1:0] prev_bits;
    logic [31:0] ed;
    int          eb;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_bits  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (force_stall && !s_ready) stall_seen_low = 1'b1;
        if (prev_stall) begin
          chk("hold_valid", 64'(m_valid), 64'd1);
          chk("hold_data", 64'(m_data), 64'(prev_data));
          chk("hold_bits", 64'(m_bits), 64'(prev_bits));
        end
        if (m_valid && m_ready) begin
          if (exp_data.size() == 0) begin
            chk("word_expected", 64'(exp_data.size()), 64'd1);
          end else begin
            ed = exp_data.pop_front();
            eb = exp_bits.pop_front();
            chk("word_data", 64'(m_data), 64'(ed));
            chk("word_bits", 64'(m_bits), 64'(eb));
          end
          last_data = m_data;
          last_bits = int'(m_bits);
          words_rx++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_bits  = m_bits;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    logic [63:0] val;
    int          rx0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_bits", 64'(m_bits), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("s_ready_idle", 64'(s_ready), 64'd1);

    // Pin the model against hand-derived codes.
    code_of(16'd13, 2, len, val);
    chk("pin_len_13_k2", 64'(len), 64'd6);
    chk("pin_val_13_k2", val, 64'h39);
    code_of(16'd20, 0, len, val);
    chk("pin_len_20_k0", 64'(len), 64'd32);
    chk("pin_val_20_k0", val, 64'hFFFF_0014);
    code_of(16'd3, 1, len, val);
    chk("pin_val_3_k1", val, 64'h5);

    // k=2, s_data=13, then flush.
    send(16'd13, 2);
    do_flush();
    chk("t1_data", 64'(last_data), 64'hE400_0000);
    chk("t1_bits", 64'(last_bits), 64'd6);

    // 32 one-bit codes fill exactly one word.
    rx0 = words_rx;
    for (int i = 0; i < 32; i++) send(16'd0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_words", 64'(words_rx - rx0), 64'd1);
    chk("t2_data", 64'(last_data), 64'h0);
    chk("t2_bits", 64'(last_bits), 64'd32);

    // Escape code.
    send(16'd20, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("t3_data", 64'(last_data), 64'hFFFF_0014);
    chk("t3_bits", 64'(last_bits), 64'd32);

    // Flush with an empty accumulator.
    rx0 = words_rx;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("t6_done_early", 64'(flush_done), 64'd0);
    chk("t6_valid0", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("t6_done", 64'(flush_done), 64'd1);
    chk("t6_valid1", 64'(m_valid), 64'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("t6_done_pulse", 64'(flush_done), 64'd0);
    chk("t6_valid2", 64'(m_valid), 64'd0);
    chk("t6_no_words", 64'(words_rx - rx0), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: downstream stalled for 20 cycles during 64 random symbols.
    stall_seen_low = 1'b0;
    fork
      begin
        force_stall = 1'b1;
        repeat (20) @(posedge clk);
        force_stall = 1'b0;
      end
    join_none
    for (int i = 0; i < 64; i++) send_rand();
    do_flush();
    chk("t4_s_ready_dropped", 64'(stall_seen_low), 64'd1);

    // Reset while the prefix of a long quotient is being written.
    send(16'd40, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_s_ready", 64'(s_ready), 64'd0);
    chk("t5_m_valid", 64'(m_valid), 64'd0);
    chk("t5_m_data", 64'(m_data), 64'd0);
    chk("t5_m_bits", 64'(m_bits), 64'd0);
    chk("t5_flush_done", 64'(flush_done), 64'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd3, 1);
    do_flush();
    chk("t5_data", 64'(last_data), 64'hA000_0000);
    chk("t5_bits", 64'(last_bits), 64'd3);

    // Random symbols, random downstream ready, occasional flushes and gaps.
    mode = 1;
    for (int i = 0; i < 150; i++) begin
      send_rand();
      if ($urandom_range(0, 19) == 0) do_flush();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    do_flush();
    mode = 0;
    chk("final_empty", 64'(exp_data.size() + bq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
